// File: rtl/fetch_buffer_if.sv
// Decode-side handshake of the fetch buffer: head entry out, consume strobe in.
interface fetch_buffer_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 8
);
   logic              fd_valid;
   logic              fd_ready;
   logic [INST_W-1:0] fd_inst;
   logic [ADDR_W-1:0] fd_pc;

   modport master (output fd_valid, output fd_inst, output fd_pc, input fd_ready);
   modport slave  (input fd_valid, input fd_inst, input fd_pc, output fd_ready);
endinterface

// File: rtl/fetch_buffer.sv
// Fetch buffer: tags each issued PC through the instruction-memory latency,
// pairs it with the returning instruction and queues both for decode.
// stall_pc reserves FIFO room for every in-flight fetch, so pushes never overflow.
module fetch_buffer #(
   parameter int LOAD_LATENCY = 1,
   parameter int DEPTH        = 4,
   parameter int ADDR_W       = 64,
   parameter int INST_W       = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [ADDR_W-1:0]          pc_to_mem,
   input  logic [INST_W-1:0]          inst_from_mem,
   input  logic                       flush,
   output logic                       stall_pc,
   fetch_buffer_if.master             fd,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + LOAD_LATENCY + 1);

   // Tag pipeline: stage 0 holds the PC issued last cycle, the last stage
   // lines up with inst_from_mem.
   logic              vld_p [LOAD_LATENCY];
   logic [ADDR_W-1:0] pc_p  [LOAD_LATENCY];

   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [OCC_W-1:0]  inflight;

   logic issue;
   logic push;
   logic pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Count fetches still waiting on memory; built from registers only.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LOAD_LATENCY; i++)
         inflight = inflight + OCC_W'(vld_p[i]);
   end

   assign stall_pc    = (OCC_W'(count) + inflight) >= OCC_W'(DEPTH);
   assign issue       = ~flush & ~stall_pc;
   assign push        = vld_p[LOAD_LATENCY-1] & ~flush;
   assign pop         = fd.fd_valid & fd.fd_ready & ~flush;

   assign fd.fd_valid = (count != '0);
   assign fd.fd_inst  = inst_mem[rd_ptr];
   assign fd.fd_pc    = pc_mem[rd_ptr];

   // Control state: tag valids, pointers and occupancy; reset and flush both empty the buffer.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         for (int i = 0; i < LOAD_LATENCY; i++)
            vld_p[i] <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         vld_p[0] <= issue;
         for (int i = 1; i < LOAD_LATENCY; i++)
            vld_p[i] <= vld_p[i-1];
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Datapath: tag PCs shift every cycle, FIFO storage written on push; no reset needed.
   always_ff @(posedge clk) begin
      pc_p[0] <= pc_to_mem;
      for (int i = 1; i < LOAD_LATENCY; i++)
         pc_p[i] <= pc_p[i-1];
      if (push) begin
         inst_mem[wr_ptr] <= inst_from_mem;
         pc_mem[wr_ptr]   <= pc_p[LOAD_LATENCY-1];
      end
   end

   // The stall reservation makes a push into a full FIFO unreachable.
   no_overflow_a: assert property (@(posedge clk) disable iff (!rstn) push |-> (count != CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: one instance with LOAD_LATENCY=1 and one
// with LOAD_LATENCY=3, each fed by a memory model returning pc[7:0].
module tb_fetch_buffer;

   logic        clk = 1'b0;
   logic        rstn1, rstn3;
   logic        flush1, flush3;
   logic [63:0] pc1, pc3;
   logic [7:0]  inst1, inst3, m3a, m3b;
   logic        stall1, stall3;
   logic [2:0]  count1, count3;

   int n_chk = 0;
   int n_err = 0;
   int max1  = 0;

   fetch_buffer_if #(.ADDR_W(64), .INST_W(8)) fd1 ();
   fetch_buffer_if #(.ADDR_W(64), .INST_W(8)) fd3 ();

   fetch_buffer #(.LOAD_LATENCY(1), .DEPTH(4), .ADDR_W(64), .INST_W(8)) u_dut1 (
      .clk(clk), .rstn(rstn1), .pc_to_mem(pc1), .inst_from_mem(inst1),
      .flush(flush1), .stall_pc(stall1), .fd(fd1), .count(count1)
   );

   fetch_buffer #(.LOAD_LATENCY(3), .DEPTH(4), .ADDR_W(64), .INST_W(8)) u_dut3 (
      .clk(clk), .rstn(rstn3), .pc_to_mem(pc3), .inst_from_mem(inst3),
      .flush(flush3), .stall_pc(stall3), .fd(fd3), .count(count3)
   );

   always #5 clk = ~clk;

   // Instruction memory models: data is the low byte of the address, LOAD_LATENCY cycles later.
   always @(posedge clk) begin
      inst1 <= pc1[7:0];
      m3a   <= pc3[7:0];
      m3b   <= m3a;
      inst3 <= m3b;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One clock; the PC sources advance only on cycles the DUT treats as issues.
   task automatic tick();
      logic iss1, iss3;
      iss1 = rstn1 && !flush1 && !stall1;
      iss3 = rstn3 && !flush3 && !stall3;
      @(posedge clk);
      #1;
      if (iss1) pc1 = pc1 + 64'd1;
      if (iss3) pc3 = pc3 + 64'd1;
      if (int'(count1) > max1) max1 = int'(count1);
   endtask

   task automatic do_reset();
      rstn1 = 1'b0; rstn3 = 1'b0;
      flush1 = 1'b0; flush3 = 1'b0;
      fd1.fd_ready = 1'b0; fd3.fd_ready = 1'b0;
      tick();
      tick();
      rstn1 = 1'b1; rstn3 = 1'b1;
      pc1 = 64'h100; pc3 = 64'h100;
   endtask

   initial begin
      int pops;
      logic [63:0] exp_pc;
      rstn1 = 1'b0; rstn3 = 1'b0;
      flush1 = 1'b0; flush3 = 1'b0;
      pc1 = 64'h100; pc3 = 64'h100;
      fd1.fd_ready = 1'b0; fd3.fd_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_valid1", fd1.fd_valid, 0);
      check("rst_count1", count1, 0);
      check("rst_stall1", stall1, 0);
      check("rst_valid3", fd3.fd_valid, 0);
      check("rst_count3", count3, 0);
      rstn1 = 1'b1; rstn3 = 1'b1;

      // Streaming, L=1: first valid two cycles after issue, then one per cycle
      fd1.fd_ready = 1'b1;
      tick();
      check("stream_lat_valid", fd1.fd_valid, 0);
      tick();
      check("stream_first_valid", fd1.fd_valid, 1);
      for (int k = 0; k < 8; k++) begin
         check("stream_pc", fd1.fd_pc, 64'h100 + 64'(k));
         check("stream_inst", fd1.fd_inst, 64'((8'h00 + 8'(k))));
         check("stream_stall", stall1, 0);
         check("stream_count", count1, 1);
         tick();
      end

      // Backpressure, L=1
      do_reset();
      tick(); tick(); tick(); tick();
      check("bp_stall_e4", stall1, 1);
      check("bp_count_e4", count1, 3);
      tick();
      check("bp_count_e5", count1, 4);
      check("bp_stall_e5", stall1, 1);
      tick(); tick();
      check("bp_count_hold", count1, 4);
      check("bp_head_hold", fd1.fd_pc, 64'h100);
      fd1.fd_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("bp_drain_valid", fd1.fd_valid, 1);
         check("bp_drain_pc", fd1.fd_pc, 64'h100 + 64'(k));
      end

      // Flush with count=2, inflight=1
      do_reset();
      tick(); tick(); tick();
      check("fl_pre_count", count1, 2);
      flush1 = 1'b1;
      tick();
      flush1 = 1'b0;
      check("fl_valid", fd1.fd_valid, 0);
      check("fl_count", count1, 0);
      check("fl_stall", stall1, 0);
      pc1 = 64'h200;
      tick();
      check("fl_no_stale_valid", fd1.fd_valid, 0);
      check("fl_no_stale_count", count1, 0);
      tick();
      check("fl_new_valid", fd1.fd_valid, 1);
      check("fl_new_pc", fd1.fd_pc, 64'h200);
      check("fl_new_inst", fd1.fd_inst, 64'h00);

      // Wrap, L=1, fd_ready pattern 1,0,0 repeating
      do_reset();
      max1 = 0;
      pops = 0;
      exp_pc = 64'h100;
      for (int k = 0; k < 200 && pops < 10; k++) begin
         fd1.fd_ready = ((k % 3) == 0);
         if (fd1.fd_valid && fd1.fd_ready) begin
            check("wrap_pc", fd1.fd_pc, exp_pc);
            check("wrap_inst", fd1.fd_inst, {56'd0, exp_pc[7:0]});
            exp_pc = exp_pc + 64'd1;
            pops++;
         end
         tick();
      end
      check("wrap_pops", 64'(pops), 10);
      check("wrap_count_le4", 64'(max1 <= 4), 1);

      // Latency parameter, L=3
      do_reset();
      tick(); tick(); tick();
      check("l3_valid_e3", fd3.fd_valid, 0);
      check("l3_stall_e3", stall3, 0);
      tick();
      check("l3_valid_e4", fd3.fd_valid, 1);
      check("l3_pc_e4", fd3.fd_pc, 64'h100);
      check("l3_stall_e4", stall3, 1);
      tick(); tick(); tick();
      check("l3_count_full", count3, 4);
      check("l3_stall_full", stall3, 1);

      // Reset mid-stream with count=3, inflight=1
      do_reset();
      tick(); tick(); tick(); tick();
      check("mr_pre_count", count1, 3);
      rstn1 = 1'b0;
      tick();
      rstn1 = 1'b1;
      check("mr_valid", fd1.fd_valid, 0);
      check("mr_count", count1, 0);
      check("mr_stall", stall1, 0);
      pc1 = 64'h300;
      fd1.fd_ready = 1'b1;
      tick();
      check("mr_no_stale", fd1.fd_valid, 0);
      tick();
      check("mr_new_valid", fd1.fd_valid, 1);
      check("mr_new_pc", fd1.fd_pc, 64'h300);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
